// File: rtl/wb_reg_bank.sv
// Pipelined Wishbone B4 register bank: byte-lane R/W control registers, read-only status
// window, and a sticky, maskable event block driving a registered interrupt.
module wb_reg_bank #(
  parameter int unsigned            CFGAW    = 32,
  parameter int unsigned            CFGDW    = 32,
  parameter int unsigned            N_CTL    = 16,
  parameter int unsigned            N_STS    = 16,
  parameter int unsigned            N_EVT    = 8,
  parameter logic [N_CTL*CFGDW-1:0] CTL_INIT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cyc_i,
  input  logic                   stb_i,
  input  logic                   we_i,
  input  logic [CFGDW/8-1:0]     sel_i,
  input  logic [CFGAW-1:0]       addr_i,
  input  logic [CFGDW-1:0]       data_i,
  output logic [CFGDW-1:0]       data_o,
  output logic                   ack_o,
  output logic                   err_o,
  output logic                   stall_o,
  output logic [N_CTL*CFGDW-1:0] ctl_regs,
  output logic [N_CTL-1:0]       ctl_wr,
  input  logic [N_STS*CFGDW-1:0] sts_regs,
  input  logic [N_EVT-1:0]       evt_i,
  output logic                   irq_o
);

  localparam int unsigned      NLanes   = CFGDW / 8;
  localparam int unsigned      NRegs    = N_CTL + N_STS;
  localparam logic [CFGAW-1:0] AddrSts  = CFGAW'(N_CTL);
  localparam logic [CFGAW-1:0] AddrPend = CFGAW'(NRegs);
  localparam logic [CFGAW-1:0] AddrEn   = CFGAW'(NRegs + 1);

  // State
  logic [N_CTL*CFGDW-1:0] ctl_q, ctl_d;
  logic [N_CTL-1:0]       ctl_wr_q, ctl_wr_d;
  logic [N_EVT-1:0]       pend_q, pend_d;
  logic [N_EVT-1:0]       en_q, en_d;
  logic [N_EVT-1:0]       evt_q;
  logic                   ack_q, err_q, irq_q;
  logic [CFGDW-1:0]       data_q, data_d;

  // Decode
  logic                   req, bad, good, wr;
  logic                   hit_ctl, hit_sts, hit_pend, hit_en;
  logic [CFGDW-1:0]       wmask;
  logic [CFGDW-1:0]       rdata;
  logic [N_EVT-1:0]       rise, clr;

  always_comb begin
    req      = cyc_i & stb_i;
    hit_ctl  = addr_i < AddrSts;
    hit_sts  = !hit_ctl && (addr_i < AddrPend);
    hit_pend = addr_i == AddrPend;
    hit_en   = addr_i == AddrEn;
    // Out-of-range or status writes terminate with err and leave all state untouched.
    bad      = req & (!(hit_ctl | hit_sts | hit_pend | hit_en) | (hit_sts & we_i));
    good     = req & ~bad;
    wr       = good & we_i;

    wmask = '0;
    for (int unsigned b = 0; b < NLanes; b++) begin
      wmask[b*8 +: 8] = {8{sel_i[b]}};
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < N_CTL; k++) begin
      if (addr_i == CFGAW'(k)) rdata = ctl_q[k*CFGDW +: CFGDW];
    end
    for (int unsigned k = 0; k < N_STS; k++) begin
      if (addr_i == CFGAW'(N_CTL + k)) rdata = sts_regs[k*CFGDW +: CFGDW];
    end
    if (hit_pend) rdata = CFGDW'(pend_q);
    if (hit_en)   rdata = CFGDW'(en_q);
  end

  always_comb begin
    ctl_d    = ctl_q;
    ctl_wr_d = '0;
    for (int unsigned k = 0; k < N_CTL; k++) begin
      if (wr && (addr_i == CFGAW'(k))) begin
        ctl_d[k*CFGDW +: CFGDW] = (ctl_q[k*CFGDW +: CFGDW] & ~wmask) | (data_i & wmask);
        ctl_wr_d[k]             = |sel_i;
      end
    end

    en_d = en_q;
    if (wr && hit_en) begin
      en_d = (en_q & ~wmask[N_EVT-1:0]) | (data_i[N_EVT-1:0] & wmask[N_EVT-1:0]);
    end

    clr = '0;
    if (wr && hit_pend) clr = data_i[N_EVT-1:0] & wmask[N_EVT-1:0];
    rise = evt_i & ~evt_q;
    // A new rise overrides a same-cycle W1C of the same bit.
    pend_d = (pend_q & ~clr) | rise;

    data_d = (good && !we_i) ? rdata : data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctl_q    <= CTL_INIT;
      ctl_wr_q <= '0;
      pend_q   <= '0;
      en_q     <= '0;
      evt_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      ctl_q    <= ctl_d;
      ctl_wr_q <= ctl_wr_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      evt_q    <= evt_i;
      ack_q    <= good;
      err_q    <= bad;
      irq_q    <= |(pend_q & en_q);
      data_q   <= data_d;
    end
  end

  assign data_o   = data_q;
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign stall_o  = 1'b0;
  assign ctl_regs = ctl_q;
  assign ctl_wr   = ctl_wr_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Bench for wb_reg_bank: directed scenarios plus randomized traffic, all checked every cycle
// against a transaction-level model of the register map.
module tb_wb_reg_bank;

  localparam logic [511:0] CtlInit = (512'hDEAD_BEEF << 96) | (512'h1234_5678 << 160) |
                                     512'hA5A5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]   sel = '0;
  logic [31:0]  addr = '0, wdata = '0;
  logic [31:0]  rdata;
  logic         ack, err, stall, irq;
  logic [511:0] ctl_regs;
  logic [15:0]  ctl_wr;
  logic [511:0] sts = '0;
  logic [7:0]   evt = '0;

  wb_reg_bank #(
    .CFGAW   (32),
    .CFGDW   (32),
    .N_CTL   (16),
    .N_STS   (16),
    .N_EVT   (8),
    .CTL_INIT(CtlInit)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cyc_i   (cyc),
    .stb_i   (stb),
    .we_i    (we),
    .sel_i   (sel),
    .addr_i  (addr),
    .data_i  (wdata),
    .data_o  (rdata),
    .ack_o   (ack),
    .err_o   (err),
    .stall_o (stall),
    .ctl_regs(ctl_regs),
    .ctl_wr  (ctl_wr),
    .sts_regs(sts),
    .evt_i   (evt),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [31:0]  m_ctl [16];
  logic [7:0]   m_pend, m_en, m_prev;
  logic         e_ack, e_err, e_irq, e_rd;
  logic [15:0]  e_wr;
  logic [31:0]  e_data;
  logic [511:0] init_img;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_ctl[k] = init_img[k*32 +: 32];
    m_pend = '0; m_en = '0; m_prev = '0;
    e_ack = 1'b0; e_err = 1'b0; e_irq = 1'b0; e_rd = 1'b0;
    e_wr = '0; e_data = '0;
  endtask

  // One bus transaction + event bookkeeping, evaluated with the inputs seen at this edge.
  task automatic model_step();
    logic [7:0]  rise, clr;
    logic [31:0] old, merged;
    logic        ok, irq_next;
    int          si;
    if (!rst) begin
      model_reset();
      return;
    end
    irq_next = |(m_pend & m_en);
    rise     = evt & ~m_prev;
    clr      = '0;
    e_wr = '0; e_ack = 1'b0; e_err = 1'b0; e_rd = 1'b0;
    if (cyc && stb) begin
      ok  = 1'b0;
      old = '0;
      if (addr < 16) begin
        ok = 1'b1; old = m_ctl[addr[3:0]];
      end else if (addr < 32) begin
        ok = !we; si = int'(addr[3:0]); old = sts[si*32 +: 32];
      end else if (addr == 32) begin
        ok = 1'b1; old = {24'b0, m_pend};
      end else if (addr == 33) begin
        ok = 1'b1; old = {24'b0, m_en};
      end
      e_ack = ok;
      e_err = !ok;
      if (ok && !we) begin
        e_data = old; e_rd = 1'b1;
      end
      if (ok && we) begin
        merged = old;
        for (int b = 0; b < 4; b++) if (sel[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
        if (addr < 16) begin
          m_ctl[addr[3:0]] = merged;
          e_wr[addr[3:0]]  = (sel != 4'b0);
        end else if (addr == 32) begin
          clr = sel[0] ? wdata[7:0] : 8'h00;
        end else begin
          m_en = merged[7:0];
        end
      end
    end
    m_pend = (m_pend & ~clr) | rise;
    m_prev = evt;
    e_irq  = irq_next;
  endtask

  task automatic compare();
    logic [511:0] img;
    for (int k = 0; k < 16; k++) img[k*32 +: 32] = m_ctl[k];
    chk("ack", ack, e_ack);
    chk("err", err, e_err);
    chk("irq", irq, e_irq);
    chk("ctl_wr", ctl_wr, e_wr);
    chk("ctl_regs", ctl_regs, img);
    chk("stall", stall, 1'b0);
    if (e_rd) chk("rdata", rdata, e_data);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    cyc = c; stb = c; we = w; addr = a; sel = s; wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
  endtask

  initial begin
    logic [31:0] r1, r2;
    init_img = CtlInit;
    model_reset();
    for (int k = 0; k < 16; k++) sts[k*32 +: 32] = 32'h5000_0000 + k;

    // Reset held for two cycles
    rst = 1'b0;
    tick();
    tick();
    chk("rst_ack", ack, 1'b0);
    rst = 1'b1;

    drive(1'b1, 1'b0, 32'd3, 4'h0, 32'd0); tick();
    chk("rst_read3_ack", ack, 1'b1);
    chk("rst_read3", rdata, 32'hDEAD_BEEF);
    chk("rst_ctlwr", ctl_wr, 16'h0);
    chk("rst_irq", irq, 1'b0);

    // Byte-lane write
    drive(1'b1, 1'b1, 32'd2, 4'b0101, 32'h1122_3344); tick();
    chk("bl_val", ctl_regs[95:64], 32'h0022_0044);
    chk("bl_pulse", ctl_wr, 16'h0004);
    idle(); tick();
    chk("bl_pulse_end", ctl_wr, 16'h0);
    drive(1'b1, 1'b1, 32'd2, 4'b0000, 32'hFFFF_FFFF); tick();
    chk("sel0_ack", ack, 1'b1);
    chk("sel0_pulse", ctl_wr, 16'h0);
    chk("sel0_val", ctl_regs[95:64], 32'h0022_0044);

    // Errors
    drive(1'b1, 1'b1, 32'd16, 4'hF, 32'hCAFE_F00D); tick();
    chk("sts_wr_err", err, 1'b1);
    chk("sts_wr_ack", ack, 1'b0);
    drive(1'b1, 1'b0, 32'd34, 4'hF, 32'd0); tick();
    chk("oor_err", err, 1'b1);
    chk("oor_ack", ack, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 4'h0, 32'd0); tick();
    chk("b2b_ack0", ack, 1'b1);
    drive(1'b1, 1'b1, 32'd16, 4'hF, 32'd0); tick();
    chk("b2b_err", err, 1'b1);
    drive(1'b1, 1'b0, 32'd1, 4'h0, 32'd0); tick();
    chk("b2b_ack1", ack, 1'b1);
    idle(); tick();

    // Events and interrupt
    drive(1'b1, 1'b1, 32'd33, 4'hF, 32'h0000_0005); tick();
    idle(); evt = 8'h04; tick();
    chk("irq_lag", irq, 1'b0);
    evt = 8'h00; tick();
    chk("irq_set", irq, 1'b1);
    drive(1'b1, 1'b0, 32'd32, 4'h0, 32'd0); tick();
    chk("pend_04", rdata, 32'h04);
    idle(); evt = 8'h02; tick();
    evt = 8'h00; tick();
    chk("irq_kept", irq, 1'b1);
    drive(1'b1, 1'b0, 32'd32, 4'h0, 32'd0); tick();
    chk("pend_06", rdata, 32'h06);

    // W1C racing a fresh rise: set wins
    evt = 8'h04;
    drive(1'b1, 1'b1, 32'd32, 4'h1, 32'h0000_0004); tick();
    evt = 8'h00;
    drive(1'b1, 1'b0, 32'd32, 4'h0, 32'd0); tick();
    chk("race_pend", rdata, 32'h06);
    chk("race_irq", irq, 1'b1);
    drive(1'b1, 1'b1, 32'd32, 4'h1, 32'h0000_0004); tick();
    chk("w1c_ack", ack, 1'b1);
    idle(); tick();
    chk("w1c_irq_drop", irq, 1'b0);
    drive(1'b1, 1'b0, 32'd32, 4'h0, 32'd0); tick();
    chk("w1c_pend", rdata, 32'h02);

    // Reset coinciding with a write strobe
    drive(1'b1, 1'b1, 32'd3, 4'hF, 32'h0BAD_0BAD);
    rst = 1'b0; tick();
    chk("rst_mid_ack", ack, 1'b0);
    chk("rst_mid_val", ctl_regs[127:96], 32'hDEAD_BEEF);
    rst = 1'b1; idle(); tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      cyc = ($urandom_range(0, 3) != 0);
      stb = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1) != 0;
      r1  = $urandom;
      addr = ($urandom_range(0, 9) == 0) ? r1 : 32'($urandom_range(0, 35));
      r2  = $urandom;
      sel = r2[3:0];
      wdata = $urandom;
      r1 = $urandom; r2 = $urandom;
      evt = evt ^ (r1[7:0] & r2[7:0]);
      if ($urandom_range(0, 7) == 0)
        for (int k = 0; k < 16; k++) sts[k*32 +: 32] = $urandom;
      tick();
    end

    idle(); rst = 1'b1; evt = 8'h00;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
